// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU-control decoder; expands iterative R-type ops into ITER_STEPS beats.
// Define ALUCTRL_TRAP_EN to flag undecodable opcodes through out_illegal.
module alu_ctrl_seq #(
  parameter int unsigned  CTRL_W     = 4,  // legal 4..6
  parameter int unsigned  ITER_STEPS = 4,  // legal 2..16
  localparam int unsigned STEP_W     = $clog2(ITER_STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] aluC,
  output logic [STEP_W-1:0] out_step,
  output logic              out_last,
  output logic              out_iter,
  output logic              out_illegal
);

  localparam logic [STEP_W-1:0] LastStep = STEP_W'(ITER_STEPS - 1);

  typedef enum logic [1:0] {StEmpty, StSingle, StIter} state_e;

  state_e            state;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_iter;
  logic              dec_illegal;
  logic              accept;
  logic              beat_done;
  logic [STEP_W-1:0] step_nxt;

  always_comb begin
    dec_ctrl    = '0;
    dec_iter    = 1'b0;
    dec_illegal = 1'b0;
    if (opcode[5]) begin
      dec_ctrl = '0;
    end else if (opcode == 6'b000000) begin
      dec_ctrl = funct[CTRL_W-1:0];
      dec_iter = (funct[5:3] == 3'b011);
    end else if (opcode == 6'b001000 || opcode[5:4] == 2'b01) begin
      dec_ctrl = CTRL_W'(1);
    end else if (opcode == 6'b001001) begin
      dec_ctrl = CTRL_W'(5);
    end
`ifdef ALUCTRL_TRAP_EN
    // Illegal opcodes already fall through to aluC=0 and are never iterative.
    dec_illegal = (opcode[5:4] == 2'b00) && (opcode != 6'b000000) &&
                  (opcode != 6'b001000) && (opcode != 6'b001001);
`else
    dec_illegal = 1'b0;
`endif
  end

  assign out_valid = (state != StEmpty);
  // The final beat frees the slot in the same cycle, so ops chain with no bubble.
  assign in_ready  = !out_valid || (out_ready && out_last);
  assign accept    = in_valid && in_ready;
  assign beat_done = out_valid && out_ready;
  assign step_nxt  = out_step + STEP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StEmpty;
      aluC        <= '0;
      out_step    <= '0;
      out_last    <= 1'b0;
      out_iter    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      state       <= dec_iter ? StIter : StSingle;
      aluC        <= dec_ctrl;
      out_step    <= '0;
      out_last    <= !dec_iter;
      out_iter    <= dec_iter;
      out_illegal <= dec_illegal;
    end else if (beat_done) begin
      unique case (state)
        StIter: begin
          if (out_last) begin
            state <= StEmpty;
          end else begin
            out_step <= step_nxt;
            out_last <= (step_nxt == LastStep);
          end
        end
        default: state <= StEmpty;
      endcase
    end
  end

endmodule
